seven_seg: RTL and testbench
============================

Name: seven_seg

Overview:
- Time-multiplexed driver for a 4-digit, common-anode 7-segment display with a decimal point.
- Each 8-bit display input is decoded to hex-digit segments.
- One decimal point is lit, on the digit selected by decplace.
- Instantiated by the command parser to show the 4-byte bitstream version; outputs go straight to board pins.

Parameters:
- CNT_WIDTH, 18, width of the free-running refresh counter. Each digit is active for 2^(CNT_WIDTH-2) clocks; 18 gives about 381 Hz per digit at 100 MHz. Legal range 3..32.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- display_0  input  8  value for digit 0 (rightmost, an[0]).
- display_1  input  8  value for digit 1.
- display_2  input  8  value for digit 2.
- display_3  input  8  value for digit 3 (leftmost, an[3]).
- decplace  input  2  index of the digit whose decimal point is lit.
- seg  output  8  active-low segments: seg[7]=dp, seg[6]=g … seg[0]=a.
- an  output  4  active-low digit enables, one-hot-low.

Behaviour:
- Reset (rstn=0, asynchronous, no clock needed): refresh counter=0, seg=8'hFF, an=4'b1111 (display dark).
- Refresh counter: CNT_WIDTH bits, increments by 1 every clk, wraps from all-ones to 0 with no gap.
- Digit index: idx = counter[CNT_WIDTH-1:CNT_WIDTH-2]. The order is 0,1,2,3,0… on each 2^(CNT_WIDTH-2)-clock boundary.
- an and seg are registered from the current counter and inputs, so they lag idx by exactly 1 clock.
  - an = ~(4'b0001 << idx); exactly one bit low in every cycle after the first post-reset edge.
- Segment decode uses display_idx[3:0], active low; bits [7:4] are ignored.
  - seg[6:0] values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- seg[7] = 0 when idx == decplace, otherwise 1.
- Inputs are not latched. A change to display_n or decplace is visible one clock later if that digit is active.
- Reset mid-scan immediately blanks the outputs. After release the scan restarts at digit 0, and the first edge drives an=4'b1110.
- No handshake. There is no error condition; all input codes are legal.

Optional Feature:
- Macro: SEVEN_SEG_RAW_EN.
- Defined: when display_n[7]=1, seg[6:0] = display_n[6:0] is driven raw (already active-low), bypassing the hex decoder. The dp rule is unchanged. When display_n[7]=0, hex decode applies as normal.
- Undefined: bits [7:4] are always ignored and hex decode always applies.

Test Plan:
- Reset check: assert rstn=0 mid-scan -> seg=FF and an=1111 immediately, with no clock edge. Release -> first edge gives an=1110.
- Scan order (CNT_WIDTH=4): inputs 8'h01/8'h02/8'h03/8'h04, decplace=2'b10.
  - an goes 1110→1101→1011→0111, each for 4 clocks, then wraps.
  - seg = F9, A4, 30, 99; dp is low only while an=1011.
- Full decode: sweep display_0 over 0x00..0x0F with digit 0 active -> seg[6:0] matches the table.
  - Upper-bit check: display_0=8'hA5 (macro undefined) -> seg[6:0]=12.
- Decimal point: cycle decplace 0..3 -> seg[7]=0 only on the matching an slot; always exactly one dp per frame.
- Input latency: change display_2 while digit 2 is active -> seg updates on the next clock edge.
- Raw mode (macro defined): display_1=8'hFF with digit 1 active -> seg[6:0]=7F, all segments off.

Source files
------------

// File: rtl/seven_seg_if.sv
// seven_seg_if: display values and decimal-point select in, active-low segment and anode drives out.
interface seven_seg_if;
  logic [7:0] display_0;
  logic [7:0] display_1;
  logic [7:0] display_2;
  logic [7:0] display_3;
  logic [1:0] decplace;
  logic [7:0] seg;
  logic [3:0] an;
  modport master (output display_0, display_1, display_2, display_3, decplace, input seg, an);
  modport slave (input display_0, display_1, display_2, display_3, decplace, output seg, an);
endinterface

// File: rtl/seven_seg.sv
// seven_seg: time-multiplexed 4-digit common-anode hex display driver with one decimal point.
// Define SEVEN_SEG_RAW_EN to drive display_n[6:0] raw when display_n[7] is set.
module seven_seg #(
  parameter int CNT_WIDTH = 18
) (
  input logic clk,
  input logic rstn,
  seven_seg_if.slave bus
);
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [7:0] r_seg;
  logic [3:0] r_an;
  logic [1:0] w_idx;
  logic [7:0] w_val;
  logic [6:0] w_hex;
  logic [6:0] w_seg;
  assign w_idx = r_cnt[CNT_WIDTH-1 -: 2];
  always_comb w_val = w_idx == 2'd0 ? bus.display_0 :
                      w_idx == 2'd1 ? bus.display_1 :
                      w_idx == 2'd2 ? bus.display_2 : bus.display_3;
  always_comb begin
    w_hex = 7'h7F;
    case (w_val[3:0])
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      4'hF: w_hex = 7'h0E;
      default: w_hex = 7'h7F;
    endcase
  end
`ifdef SEVEN_SEG_RAW_EN
  assign w_seg = w_val[7] ? w_val[6:0] : w_hex;
`else
  logic w_unused;
  assign w_unused = ^w_val[7:4];
  assign w_seg = w_hex;
`endif
  // outputs lag the scan index by one clock; reset blanks the display
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_seg <= 8'hFF;
      r_an <= 4'b1111;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_seg <= {w_idx != bus.decplace, w_seg};
      r_an <= ~(4'b0001 << w_idx);
    end
  end
  assign bus.seg = r_seg;
  assign bus.an = r_an;
endmodule

// File: tb/tb_seven_seg.sv
// tb_seven_seg: table-driven and directed checks of seven_seg with CNT_WIDTH=4 (4 clocks per digit).
module tb_seven_seg;
  typedef struct {
    logic [7:0] d0, d1, d2, d3;
    logic [1:0] dp;
    int adv;
    logic [7:0] seg;
    logic [3:0] an;
  } vec_t;
`ifdef SEVEN_SEG_RAW_EN
  localparam logic [7:0] EXP_A5 = 8'h25;
  localparam logic [7:0] EXP_FF = 8'h7F;
`else
  localparam logic [7:0] EXP_A5 = 8'h12;
  localparam logic [7:0] EXP_FF = 8'h0E;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  seven_seg_if bus ();
  seven_seg #(.CNT_WIDTH(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic restart();
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
  endtask
  task automatic drive(input logic [7:0] a, b, c, d, input logic [1:0] p);
    bus.display_0 = a;
    bus.display_1 = b;
    bus.display_2 = c;
    bus.display_3 = d;
    bus.decplace = p;
  endtask
  initial begin
    vec_t v[18];
    logic [6:0] hex_tbl[16];
    logic [7:0] scan_seg[4];
    logic [3:0] scan_an[4];
    int slot;
    int low;
    hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    scan_seg = '{8'hF9, 8'hA4, 8'h30, 8'h99};
    scan_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 16; i++)
      v[i] = '{8'(i), 8'h00, 8'h00, 8'h00, 2'd3, 1, {1'b1, hex_tbl[i]}, 4'b1110};
    v[16] = '{8'hA5, 8'h00, 8'h00, 8'h00, 2'd0, 1, EXP_A5, 4'b1110};
    v[17] = '{8'h00, 8'hFF, 8'h00, 8'h00, 2'd1, 5, EXP_FF, 4'b1101};
    drive(8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    tick(3);
    rstn = 1'b0;
    #1;
    chk("rst_seg_async", bus.seg, 8'hFF);
    chk("rst_an_async", {4'h0, bus.an}, 8'h0F);
    tick(2);
    chk("rst_seg_held", bus.seg, 8'hFF);
    chk("rst_an_held", {4'h0, bus.an}, 8'h0F);
    drive(8'h01, 8'h02, 8'h03, 8'h04, 2'd2);
    rstn = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick(1);
      slot = ((e - 1) / 4) % 4;
      chk($sformatf("scan_an_e%0d", e), {4'h0, bus.an}, {4'h0, scan_an[slot]});
      chk($sformatf("scan_seg_e%0d", e), bus.seg, scan_seg[slot]);
    end
    tick(2);
    rstn = 1'b0;
    #1;
    chk("midscan_rst_seg", bus.seg, 8'hFF);
    chk("midscan_rst_an", {4'h0, bus.an}, 8'h0F);
    rstn = 1'b1;
    tick(1);
    chk("post_rst_an", {4'h0, bus.an}, 8'h0E);
    chk("post_rst_seg", bus.seg, 8'hF9);
    for (int i = 0; i < 18; i++) begin
      restart();
      drive(v[i].d0, v[i].d1, v[i].d2, v[i].d3, v[i].dp);
      tick(v[i].adv);
      chk($sformatf("vec%0d_seg", i), bus.seg, v[i].seg);
      chk($sformatf("vec%0d_an", i), {4'h0, bus.an}, {4'h0, v[i].an});
    end
    for (int k = 0; k < 4; k++) begin
      restart();
      drive(8'h08, 8'h08, 8'h08, 8'h08, 2'(k));
      low = 0;
      for (int e = 1; e <= 16; e++) begin
        tick(1);
        slot = (e - 1) / 4;
        chk($sformatf("dp%0d_e%0d", k, e), {7'h0, bus.seg[7]}, {7'h0, slot != k});
        if (bus.seg[7] === 1'b0) low++;
      end
      chk($sformatf("dp%0d_count", k), 8'(low), 8'd4);
    end
    restart();
    drive(8'h00, 8'h00, 8'h03, 8'h00, 2'd3);
    tick(9);
    chk("lat_before_seg", bus.seg, 8'hB0);
    chk("lat_before_an", {4'h0, bus.an}, 8'h0B);
    bus.display_2 = 8'h05;
    tick(1);
    chk("lat_after_seg", bus.seg, 8'h92);
    chk("lat_after_an", {4'h0, bus.an}, 8'h0B);
    bus.decplace = 2'd2;
    tick(1);
    chk("lat_dp_seg", bus.seg, 8'h12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
